// File: rtl/x_ramd_pkg.sv
// x_ramd_pkg: shared FSM type, mode names and helper functions for the x_ramd_param RAM
package x_ramd_pkg;

    typedef enum logic {CLR, RUN} state_t;

    localparam string MODE_RF = "READ_FIRST";
    localparam string MODE_WF = "WRITE_FIRST";

    // widest word the parity helper can fold
    localparam int PAR_MAX = 1024;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // even parity: the extra bit makes the total number of ones even
    function automatic logic even_par(input logic [PAR_MAX-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/x_ramd_clr_seq.sv
// x_ramd_clr_seq: post-reset clear sequencer that walks every address once to reload INIT
module x_ramd_clr_seq import x_ramd_pkg::*; #(
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_adr
);

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] r_ptr;

    // state and pointer; reset always restarts the clear from word 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= CLR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (o_clr_we) r_ptr <= r_ptr + 1'b1;
        end
    end

    // leave CLR on the edge that writes the last word; strobe every CLR cycle
    always_comb begin
        w_state_nx = (r_state == CLR && &r_ptr) ? RUN : r_state;
        o_busy     = r_state == CLR;
        o_clr_we   = r_state == CLR;
        o_clr_adr  = r_ptr;
    end

endmodule

// File: rtl/x_ramd_param.sv
// x_ramd_param: parametrised dual-port LUT RAM with INIT reload on reset; optional parity via X_RAMD_PARITY_EN
module x_ramd_param import x_ramd_pkg::*; #(
    parameter int                     WIDTH      = 1,
    parameter int                     DEPTH      = 32,
    parameter logic [WIDTH*DEPTH-1:0] INIT       = '0,
    parameter int                     OUT_REG    = 0,
    parameter string                  WRITE_MODE = MODE_RF,
    localparam int                    AW         = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WADR,
    input  logic [WIDTH-1:0] I,
    input  logic             RE,
    input  logic [AW-1:0]    RADR,
    output logic [WIDTH-1:0] O,
`ifdef X_RAMD_PARITY_EN
    input  logic             ERR_INJ,
    output logic             PERR,
`endif
    output logic             BUSY
);

`ifdef X_RAMD_PARITY_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "x_ramd_param: DEPTH must be a power of 2 and at least 2");
    end
    if (WRITE_MODE != MODE_RF && WRITE_MODE != MODE_WF) begin : g_bad_mode
        $fatal(1, "x_ramd_param: WRITE_MODE must be READ_FIRST or WRITE_FIRST");
    end
`ifdef X_RAMD_PARITY_EN
    if (WIDTH > PAR_MAX) begin : g_bad_width
        $fatal(1, "x_ramd_param: WIDTH too large for parity");
    end
`endif

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_adr;
    logic [WIDTH-1:0] w_init_word;
    logic [DW-1:0]    w_wr_ent;
    logic [DW-1:0]    w_init_ent;
    logic [DW-1:0]    w_rd_ent;
    logic [DW-1:0]    w_out;
    logic [DW-1:0]    r_mem [DEPTH];

    x_ramd_clr_seq #(.AW(AW)) u_clr (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .o_busy    (w_busy),
        .o_clr_we  (w_clr_we),
        .o_clr_adr (w_clr_adr)
    );

    assign w_init_word = INIT[int'(w_clr_adr) * WIDTH +: WIDTH];

`ifdef X_RAMD_PARITY_EN
    assign w_wr_ent   = {even_par(PAR_MAX'(I)) ^ ERR_INJ, I};
    assign w_init_ent = {even_par(PAR_MAX'(w_init_word)), w_init_word};
    assign PERR       = even_par(PAR_MAX'(w_out[WIDTH-1:0])) != w_out[WIDTH];
`else
    assign w_wr_ent   = I;
    assign w_init_ent = w_init_word;
`endif

    // clear has priority; user writes land only out of reset and in RUN
    always_ff @(posedge CLK) begin
        if (RST && w_clr_we) r_mem[w_clr_adr] <= w_init_ent;
        else if (RST && WE && !w_busy) r_mem[WADR] <= w_wr_ent;
    end

    assign w_rd_ent = r_mem[RADR];

    if (OUT_REG != 0) begin : g_reg
        localparam bit WF = WRITE_MODE == MODE_WF;
        logic [DW-1:0] r_out;
        // registered read, zero through reset and clear; WRITE_FIRST forwards colliding write data
        always_ff @(posedge CLK) begin
            if (!RST || w_busy) r_out <= '0;
            else if (RE) r_out <= (WF && WE && WADR == RADR) ? w_wr_ent : w_rd_ent;
        end
        assign w_out = r_out;
    end else begin : g_async
        logic w_unused_re;
        assign w_unused_re = RE;
        assign w_out       = w_busy ? '0 : w_rd_ent;
    end

    assign O    = w_out[WIDTH-1:0];
    assign BUSY = w_busy;

endmodule

// File: tb/tb_x_ramd_param.sv
// tb_x_ramd_param: random and directed checks of async, READ_FIRST and WRITE_FIRST RAM instances against an array model
module tb_x_ramd_param;

    localparam int W = 8;
    localparam int D = 64;

    logic       clk = 1'b0;
    logic       rst, we, re, einj;
    logic [5:0] wadr, radr;
    logic [7:0] din;
    logic [7:0] o_a, o_rf, o_wf;
    logic       b_a, b_rf, b_wf;
`ifdef X_RAMD_PARITY_EN
    logic       p_a, p_rf, p_wf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_mem [D];
    bit         m_bad [D];
    int         clr_left;
    logic [7:0] m_rf, m_wf;
    bit         m_prf, m_pwf;

    always #5 clk = ~clk;

    function automatic logic [W*D-1:0] mk_init();
        logic [W*D-1:0] v;
        for (int k = 0; k < D; k++) v[k*W +: W] = 8'(k);
        return v;
    endfunction

    x_ramd_param #(.WIDTH(W), .DEPTH(D), .INIT(mk_init()), .OUT_REG(0)) u_a (
        .CLK(clk), .RST(rst), .WE(we), .WADR(wadr), .I(din), .RE(re), .RADR(radr), .O(o_a),
`ifdef X_RAMD_PARITY_EN
        .ERR_INJ(einj), .PERR(p_a),
`endif
        .BUSY(b_a));

    x_ramd_param #(.WIDTH(W), .DEPTH(D), .INIT(mk_init()), .OUT_REG(1), .WRITE_MODE("READ_FIRST")) u_rf (
        .CLK(clk), .RST(rst), .WE(we), .WADR(wadr), .I(din), .RE(re), .RADR(radr), .O(o_rf),
`ifdef X_RAMD_PARITY_EN
        .ERR_INJ(einj), .PERR(p_rf),
`endif
        .BUSY(b_rf));

    x_ramd_param #(.WIDTH(W), .DEPTH(D), .INIT(mk_init()), .OUT_REG(1), .WRITE_MODE("WRITE_FIRST")) u_wf (
        .CLK(clk), .RST(rst), .WE(we), .WADR(wadr), .I(din), .RE(re), .RADR(radr), .O(o_wf),
`ifdef X_RAMD_PARITY_EN
        .ERR_INJ(einj), .PERR(p_wf),
`endif
        .BUSY(b_wf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit busy;
        busy = clr_left > 0;
        chk("busy_a", b_a, busy);
        chk("busy_rf", b_rf, busy);
        chk("busy_wf", b_wf, busy);
        chk("o_async", o_a, busy ? 8'h00 : m_mem[radr]);
        chk("o_rf", o_rf, m_rf);
        chk("o_wf", o_wf, m_wf);
`ifdef X_RAMD_PARITY_EN
        chk("perr_async", p_a, busy ? 1'b0 : m_bad[radr]);
        chk("perr_rf", p_rf, m_prf);
        chk("perr_wf", p_wf, m_pwf);
`endif
    endtask

    // drive one cycle from a falling edge, advance the model at the rising edge, check at the next falling edge
    task automatic tick(input logic r, input logic w, input logic e, input logic [5:0] wa,
                        input logic [5:0] ra, input logic [7:0] d, input logic ei);
        rst = r; we = w; re = e; wadr = wa; radr = ra; din = d; einj = ei;
        @(posedge clk);
        if (!r) begin
            clr_left = D;
            m_rf = '0; m_wf = '0; m_prf = 0; m_pwf = 0;
        end else if (clr_left > 0) begin
            m_mem[D-clr_left] = 8'(D - clr_left);
            m_bad[D-clr_left] = 0;
            clr_left--;
            m_rf = '0; m_wf = '0; m_prf = 0; m_pwf = 0;
        end else begin
            if (e) begin
                m_rf  = m_mem[ra];
                m_prf = m_bad[ra];
                m_wf  = (w && wa == ra) ? d : m_mem[ra];
                m_pwf = (w && wa == ra) ? ei : m_bad[ra];
            end
            if (w) begin
                m_mem[wa] = d;
                m_bad[wa] = ei;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic rnd_tick(input logic r);
        tick(r, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        int n;
        clr_left = D;
        m_rf = '0; m_wf = '0; m_prf = 0; m_pwf = 0;
        repeat (3) rnd_tick(1'b0);
        chk("rst_busy", b_a, 1'b1);
        chk("rst_o_rf", o_rf, 8'h00);
        chk("rst_o_wf", o_wf, 8'h00);

        tick(1'b1, 1'b1, 1'b1, 6'd2, 6'd2, 8'hFF, 1'b0);
        n = 1;
        while (b_a && n < 200) begin
            rnd_tick(1'b1);
            n++;
        end
        chk("busy_len", n, D);

        for (int a = 0; a < D; a++) begin
            tick(1'b1, 1'b0, 1'b1, 6'd0, 6'(a), 8'h00, 1'b0);
            chk("sweep_async", o_a, a);
            chk("sweep_rf", o_rf, a);
        end

        tick(1'b1, 1'b1, 1'b0, 6'd17, 6'd17, 8'hA5, 1'b0);
        chk("a5_async", o_a, 8'hA5);
        tick(1'b1, 1'b0, 1'b1, 6'd0, 6'd17, 8'h00, 1'b0);
        chk("a5_rf", o_rf, 8'hA5);
        chk("a5_wf", o_wf, 8'hA5);

        tick(1'b1, 1'b1, 1'b1, 6'd5, 6'd5, 8'h3C, 1'b0);
        chk("col_rf", o_rf, 8'h05);
        chk("col_wf", o_wf, 8'h3C);
        tick(1'b1, 1'b0, 1'b1, 6'd0, 6'd5, 8'h00, 1'b0);
        chk("col_next_rf", o_rf, 8'h3C);
        chk("col_next_wf", o_wf, 8'h3C);

`ifdef X_RAMD_PARITY_EN
        tick(1'b1, 1'b1, 1'b0, 6'd9, 6'd9, 8'h01, 1'b1);
        chk("par_inj_o", o_a, 8'h01);
        chk("par_inj_perr", p_a, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 6'd0, 6'd9, 8'h00, 1'b0);
        chk("par_inj_perr_rf", p_rf, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 6'd9, 6'd9, 8'h01, 1'b0);
        chk("par_clean_perr", p_a, 1'b0);
`endif

        rnd_tick(1'b0);
        repeat (30) rnd_tick(1'b1);
        chk("mid_busy", b_a, 1'b1);
        rnd_tick(1'b0);
        n = 0;
        while (b_a && n < 200) begin
            rnd_tick(1'b1);
            n++;
        end
        chk("busy_len_restart", n, D);
        for (int a = 0; a < D; a++) begin
            tick(1'b1, 1'b0, 1'b1, 6'd0, 6'(a), 8'h00, 1'b0);
            chk("reinit_async", o_a, a);
        end

        repeat (600) rnd_tick(1'($urandom_range(0, 99) != 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x_ramd_param.md
Name: x_ramd_param

Overview:
- Parametrised dual-port distributed RAM for the simprims library; the next generation of the fixed 32x1 dual-port primitive.
- Adds configurable word width and depth, an optional registered read port with a selectable collision mode, and a synchronous clear sequencer that rewrites INIT contents after every reset.
- Used wherever the netlist maps wide or deep LUT-RAM that the fixed 16/32-deep cells cannot represent.

Parameters:
- WIDTH, 1, data word width in bits.
- DEPTH, 32, number of words; power of 2, at least 2. AW = clog2(DEPTH).
- INIT, all zeros, WIDTH*DEPTH bits; word k is INIT[k*WIDTH +: WIDTH].
- OUT_REG, 0, 0 = asynchronous read (primitive-compatible), 1 = registered read with latency 1.
- WRITE_MODE, "READ_FIRST", collision policy for OUT_REG=1: "READ_FIRST" or "WRITE_FIRST".

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-low reset.
- WE  in  1  write enable.
- WADR  in  AW  write address.
- I  in  WIDTH  write data.
- RE  in  1  read enable; used only when OUT_REG=1.
- RADR  in  AW  read address.
- O  out  WIDTH  read data.
- BUSY  out  1  clear sequencer active.

Behaviour:
- Elaboration: fatal error if DEPTH is not a power of 2, DEPTH < 2, or WRITE_MODE is not one of the two legal values.
- Clear FSM states: CLR, RUN.
  - RST=0 at a rising edge: state <= CLR, ptr <= 0, registered O <= 0. BUSY=1 whenever state is CLR.
  - In CLR with RST=1: mem[ptr] <= INIT word ptr, ptr <= ptr+1. After the edge that writes ptr = DEPTH-1, state <= RUN.
  - BUSY is therefore high for exactly DEPTH cycles after reset release. Reset during CLR restarts the clear from ptr 0.
- Writes: mem[WADR] <= I on the rising edge when WE=1, RST=1 and state=RUN. WE while BUSY=1 is dropped, not queued.
- Read with OUT_REG=0: O = mem[RADR], combinational. O = 0 while BUSY=1. A write is visible on O after the write edge.
- Read with OUT_REG=1:
  - O <= mem[RADR] on an edge with RE=1 in RUN. O holds when RE=0.
  - O <= 0 on reset and throughout CLR.
  - Collision (WE=1, RE=1, WADR=RADR in the same cycle): READ_FIRST returns the old word; WRITE_FIRST returns I.
- Simultaneous reset and write: reset wins and the write is dropped.
- Address arithmetic is unsigned AW-bit; there is no out-of-range case.

Optional Feature:
- Macro: X_RAMD_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit, computed from I on write and from the INIT word during clear.
  - New input ERR_INJ (1 bit) inverts the stored parity bit on any accepted write.
  - New output PERR (1 bit) follows the same timing as O (combinational or registered). PERR=1 when the read word's parity mismatches; PERR is 0 while BUSY=1 and on reset.
- When undefined: no ERR_INJ or PERR ports, and storage is WIDTH bits per word.

Decomposition:
- Package x_ramd_pkg:
  - FSM state enum {CLR, RUN}.
  - clog2 function.
  - WRITE_MODE string constants.
  - Even-parity function.
- Sub-module x_ramd_clr_seq: owns the state, ptr counter and BUSY. Outputs the clear write strobe and clear address to the array, which muxes them against the user write port.

Test Plan:
- WIDTH=8, DEPTH=64, INIT word k = k. Hold RST=0 for 3 cycles, then release -> BUSY=1 for exactly 64 cycles, then 0. Sweep RADR 0..63 -> O = RADR.
- OUT_REG=0: write 0xA5 to address 17, then RADR=17 -> O=0xA5 in the cycle after the write edge. OUT_REG=1 with RE=1 -> O=0xA5 one cycle after RADR is presented.
- OUT_REG=1, WADR=RADR=5, WE=RE=1, I=0x3C: READ_FIRST -> O=0x05; WRITE_FIRST -> O=0x3C. The next read of 5 returns 0x3C in both modes.
- WE=1, WADR=2, I=0xFF during BUSY -> after the clear, address 2 reads 0x02 and BUSY never glitches.
- Drop RST to 0 at clear cycle 30, then release -> BUSY stays high, exactly 64 further cycles, all words equal INIT. Registered O=0 throughout.
- With X_RAMD_PARITY_EN: write 0x01 with ERR_INJ=1 to address 9, then read 9 -> O=0x01, PERR=1. Rewrite with ERR_INJ=0 -> PERR=0.
